mem_port_arbiter: RTL and testbench

- Shares the single byte-addressable data memory port between the instruction-fetch requester (I) and the load/store requester (D), for a unified-memory build of the pipelined RV32 core.
- Registers the winning request, drives one memory access, captures read data and returns a one-cycle ack.
- Rejects misaligned or unsupported-width accesses without touching memory.
- The pipeline stalls on any requester whose req is high and ack is low.

---
 rtl/mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one byte-addressable data memory port between the instruction-fetch
// requester (I) and the load/store requester (D) of a unified-memory RV32
// pipeline. A winning request is registered in IDLE, drives exactly one
// memory access in ACCESS, and is answered with a one-cycle ack in RESP.
// Misaligned or unsupported-width requests skip ACCESS and are answered with
// err set, so memory is never touched for them.
//
// The memory performs the func3 sign/zero extension itself, so captured read
// data is passed back to the requester unchanged.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr                  fetch request (always a word access)
//   i_ack/i_rdata/i_err           fetch completion pulse, data, misalign flag
//   d_req/d_we/d_func3/d_addr/d_wdata   load/store request
//   d_ack/d_rdata/d_err           load/store completion pulse, data, error
//   mem_read/mem_write/mem_func3/mem_addr/mem_wdata   memory command
//   mem_rdata                     memory read data (combinational)
//   busy                          FSM is in ACCESS or RESP
//
// Optional feature (macro MEM_ARB_FAIRNESS_EN):
//   A streak counter limits consecutive D grants to MAX_D_STREAK while I is
//   waiting; when the limit is reached and both request, I wins. Without the
//   macro D has strict priority and no counter exists.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Request registers for the access in flight
    logic              ownerD_q;
    logic              we_q;
    logic              err_q;
    logic [2:0]        memFunc3_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [31:0]       memWdata_q;
    logic [31:0]       iRdata_q;
    logic [31:0]       dRdata_q;

    // Winner selection (valid only in IDLE)
    logic              grantD;
    logic              grantI;
    logic              selWe;
    logic [2:0]        selFunc3;
    logic [ADDR_W-1:0] selAddr;
    logic              selErr;

    // Returns 1 when the access is misaligned for its width or the funct3
    // encoding is not a legal load/store (stores have no unsigned forms).
    function automatic logic accessIllegal(input logic       we,
                                           input logic [2:0] f3,
                                           input logic [1:0] a);
        logic bad;
        case (f3)
            3'd0:    bad = 1'b0;
            3'd1:    bad = a[0];
            3'd2:    bad = (a != 2'b00);
            3'd4:    bad = we;
            3'd5:    bad = we | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int STREAK_W = ($clog2(MAX_D_STREAK + 1) > 3) ? $clog2(MAX_D_STREAK + 1) : 3;

    logic [STREAK_W-1:0] streak_q;

    // I is forced through once D has won MAX_D_STREAK times in a row
    // while I was waiting.
    always_comb begin
        grantD = 1'b0;
        grantI = 1'b0;
        if (state_q == IDLE) begin
            if (d_req && !(i_req && (streak_q == STREAK_W'(MAX_D_STREAK)))) begin
                grantD = 1'b1;
            end else if (i_req) begin
                grantI = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else if (grantI) begin
            streak_q <= '0;
        end else if (grantD) begin
            streak_q <= i_req ? streak_q + 1'b1 : '0;
        end
    end
`else
    // Parameter only matters for the fairness build; referenced here so the
    // default build carries no dangling parameter.
    logic unusedMaxStreak;
    assign unusedMaxStreak = (MAX_D_STREAK != 0);

    always_comb begin
        grantD = 1'b0;
        grantI = 1'b0;
        if (state_q == IDLE) begin
            if (d_req) begin
                grantD = 1'b1;
            end else if (i_req) begin
                grantI = 1'b1;
            end
        end
    end
`endif

    // Fetches are always word loads
    always_comb begin
        selWe    = grantD ? d_we : 1'b0;
        selFunc3 = grantD ? d_func3 : 3'd2;
        selAddr  = grantD ? d_addr : i_addr;
        selErr   = accessIllegal(selWe, selFunc3, selAddr[1:0]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grantD || grantI) begin
                    state_d = selErr ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching and read-data capture. The memory command registers
    // load only for requests that will reach ACCESS, so a rejected request
    // leaves the memory bus exactly as it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            ownerD_q   <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            memFunc3_q <= '0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            iRdata_q   <= '0;
            dRdata_q   <= '0;
        end else begin
            if (grantD || grantI) begin
                ownerD_q <= grantD;
                we_q     <= selWe;
                err_q    <= selErr;
                if (!selErr) begin
                    memFunc3_q <= selFunc3;
                    memAddr_q  <= selAddr;
                    if (grantD) begin
                        memWdata_q <= d_wdata;
                    end
                end
            end
            if (state_q == ACCESS) begin
                if (!ownerD_q) begin
                    iRdata_q <= mem_rdata;
                end else if (!we_q) begin
                    dRdata_q <= mem_rdata;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        busy      = (state_q != IDLE);
        mem_read  = (state_q == ACCESS) && !we_q;
        mem_write = (state_q == ACCESS) && we_q;
        i_ack     = (state_q == RESP) && !ownerD_q;
        d_ack     = (state_q == RESP) && ownerD_q;
        i_err     = i_ack && err_q;
        d_err     = d_ack && err_q;
        mem_func3 = memFunc3_q;
        mem_addr  = memAddr_q;
        mem_wdata = memWdata_q;
        i_rdata   = iRdata_q;
        d_rdata   = dRdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A small byte memory model that
// implements RV32 load/store widths sits on the memory port. Expected values
// are hand-computed from the preloaded memory image and the stores issued.
// Fairness expectations follow MEM_ARB_FAIRNESS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_func3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_func3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int rdCount = 0;
    int wrCount = 0;

    logic [7:0] memArr [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .MAX_D_STREAK(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Memory model: combinational extended read, write on posedge
    always_comb begin
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = mem_addr[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        mem_rdata = '0;
        case (mem_func3)
            3'd0: mem_rdata = {{24{memArr[a0][7]}}, memArr[a0]};
            3'd1: mem_rdata = {{16{memArr[a1][7]}}, memArr[a1], memArr[a0]};
            3'd2: mem_rdata = {memArr[a3], memArr[a2], memArr[a1], memArr[a0]};
            3'd4: mem_rdata = {24'd0, memArr[a0]};
            3'd5: mem_rdata = {16'd0, memArr[a1], memArr[a0]};
            default: mem_rdata = '0;
        endcase
    end

    initial begin
        for (int k = 0; k < 256; k++) memArr[k] = 8'h00;
        memArr[8'h10] = 8'hEF; memArr[8'h11] = 8'hBE; memArr[8'h12] = 8'hAD; memArr[8'h13] = 8'hDE;
        memArr[8'h14] = 8'h0D; memArr[8'h15] = 8'hF0; memArr[8'h16] = 8'hFE; memArr[8'h17] = 8'hCA;
        forever begin
            @(posedge clk);
            if (mem_write) begin
                memArr[mem_addr[7:0]] <= mem_wdata[7:0];
                if (mem_func3 == 3'd1 || mem_func3 == 3'd2)
                    memArr[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
                if (mem_func3 == 3'd2) begin
                    memArr[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                    memArr[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_read)  rdCount <= rdCount + 1;
        if (mem_write) wrCount <= wrCount + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memWord(input logic [7:0] a);
        return {memArr[a + 8'd3], memArr[a + 8'd2], memArr[a + 8'd1], memArr[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one D request, wait (bounded) for its ack, drop req, return to IDLE
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] rdata, output logic err);
        d_req = 1'b1; d_we = we; d_func3 = f3; d_addr = addr; d_wdata = wdata;
        lat = 0;
        while (lat < 8 && !d_ack) begin
            tick();
            lat++;
        end
        rdata = d_rdata;
        err = d_err;
        d_req = 1'b0;
        tick();
    endtask

    task automatic runFetch(input logic [31:0] addr, output int lat,
                            output logic [31:0] rdata, output logic err);
        i_req = 1'b1; i_addr = addr;
        lat = 0;
        while (lat < 8 && !i_ack) begin
            tick();
            lat++;
        end
        rdata = i_rdata;
        err = i_err;
        i_req = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        int snap;
        int dAckAt;
        int iAckAt;
        int nD;
        int nI;
        int fifthIsI;
        int bothAck;
        logic [31:0] rd;
        logic er;

        rst = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_func3 = '0; d_addr = '0; d_wdata = '0;
        tick(); tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        checkOutput("rst_memctl", {30'd0, mem_read, mem_write}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_i_rdata", i_rdata, 32'd0);

        $display("[TB] single fetch");
        snap = rdCount;
        runFetch(32'h10, lat, rd, er);
        checkOutput("fetch_lat", 32'(lat), 32'd2);
        checkOutput("fetch_rdata", rd, 32'hDEADBEEF);
        checkOutput("fetch_err", 32'(er), 32'd0);
        checkOutput("fetch_rdcount", 32'(rdCount - snap), 32'd1);

        $display("[TB] simultaneous D store and I fetch");
        d_req = 1'b1; d_we = 1'b1; d_func3 = 3'd2; d_addr = 32'h20; d_wdata = 32'h12345678;
        i_req = 1'b1; i_addr = 32'h14;
        dAckAt = 0; iAckAt = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (d_ack) begin
                dAckAt = t;
                checkOutput("store_ack_err", 32'(d_err), 32'd0);
                checkOutput("store_ack_rdata", d_rdata, 32'd0);
                checkOutput("store_ack_i_waits", 32'(i_ack), 32'd0);
                d_req = 1'b0;
            end
            if (i_ack) begin
                iAckAt = t;
                i_req = 1'b0;
            end
        end
        checkOutput("both_d_ack_cycle", 32'(dAckAt), 32'd2);
        checkOutput("both_i_ack_cycle", 32'(iAckAt), 32'd5);
        checkOutput("both_i_rdata", i_rdata, 32'hCAFEF00D);
        checkOutput("store_mem_word", memWord(8'h20), 32'h12345678);

        $display("[TB] loads with extension");
        applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, lat, rd, er);
        checkOutput("lw_rdata", rd, 32'h12345678);
        applyStimulus(1'b1, 3'd0, 32'h21, 32'h00000080, lat, rd, er);
        checkOutput("sb_err", 32'(er), 32'd0);
        checkOutput("sb_mem_word", memWord(8'h20), 32'h12348078);
        applyStimulus(1'b0, 3'd0, 32'h21, 32'h0, lat, rd, er);
        checkOutput("lb_rdata", rd, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'd5, 32'h22, 32'h0, lat, rd, er);
        checkOutput("lhu_rdata", rd, 32'h00001234);
        applyStimulus(1'b0, 3'd4, 32'h21, 32'h0, lat, rd, er);
        checkOutput("lbu_rdata", rd, 32'h00000080);
        checkOutput("lbu_lat", 32'(lat), 32'd2);

        $display("[TB] rejected requests");
        snap = wrCount;
        applyStimulus(1'b1, 3'd2, 32'h22, 32'hAAAAAAAA, lat, rd, er);
        checkOutput("sw_mis_lat", 32'(lat), 32'd1);
        checkOutput("sw_mis_err", 32'(er), 32'd1);
        checkOutput("sw_mis_no_write", 32'(wrCount - snap), 32'd0);
        checkOutput("sw_mis_mem", memWord(8'h20), 32'h12348078);
        checkOutput("sw_mis_rdata_kept", rd, 32'h00000080);
        applyStimulus(1'b0, 3'd3, 32'h20, 32'h0, lat, rd, er);
        checkOutput("f3_3_err", 32'(er), 32'd1);
        applyStimulus(1'b1, 3'd4, 32'h20, 32'h0, lat, rd, er);
        checkOutput("sbu_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 3'd1, 32'h21, 32'h0, lat, rd, er);
        checkOutput("lh_odd_err", 32'(er), 32'd1);
        runFetch(32'h12, lat, rd, er);
        checkOutput("fetch_mis_err", 32'(er), 32'd1);
        checkOutput("fetch_mis_lat", 32'(lat), 32'd1);
        checkOutput("fetch_mis_rdata_kept", rd, 32'hCAFEF00D);

        $display("[TB] reset during ACCESS");
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h10;
        tick();
        checkOutput("abort_in_access", {30'd0, busy, mem_read}, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_idle", {29'd0, busy, i_ack, d_ack}, 32'd0);
        checkOutput("abort_d_rdata", d_rdata, 32'd0);
        lat = 0;
        while (lat < 8 && !d_ack) begin
            tick();
            lat++;
        end
        checkOutput("reissue_lat", 32'(lat), 32'd2);
        checkOutput("reissue_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        tick();

        $display("[TB] sustained contention");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h20;
        i_req = 1'b1; i_addr = 32'h10;
        nD = 0; nI = 0; fifthIsI = 0; bothAck = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (d_ack && i_ack) bothAck++;
            if (d_ack) nD++;
            if (i_ack) begin
                nI++;
                if (nD + nI == 5) fifthIsI = 1;
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        tick();
        checkOutput("contend_both_ack", 32'(bothAck), 32'd0);
`ifdef MEM_ARB_FAIRNESS_EN
        checkOutput("contend_d_acks", 32'(nD), 32'd8);
        checkOutput("contend_i_acks", 32'(nI), 32'd2);
        checkOutput("contend_fifth_is_i", 32'(fifthIsI), 32'd1);
`else
        checkOutput("contend_d_acks", 32'(nD), 32'd10);
        checkOutput("contend_i_acks", 32'(nI), 32'd0);
        checkOutput("contend_fifth_is_i", 32'(fifthIsI), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
